// File: rtl/conv_window_gen_pkg.sv
// Shared types and constants for the 3x3 convolution window generator.
package conv_pkg;

  localparam int unsigned WIN_K     = 3;
  localparam int unsigned WIN_WORDS = WIN_K * WIN_K;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDrain,
    StDone
  } win_state_t;

endpackage

// File: rtl/conv_window_gen_if.sv
// Control, pixel-stream, line-buffer and window-stream signals of conv_window_gen.
interface conv_window_gen_if #(
  parameter int unsigned WIDTH = 64
);
  import conv_pkg::*;

  logic [7:0]                 cfg_cols;
  logic [7:0]                 cfg_rows;
  logic                       cfg_stride2;
  logic                       start;
  logic                       busy;
  logic                       done;
  logic                       in_valid;
  logic                       in_ready;
  logic [WIDTH-1:0]           in_pix;
  logic                       line_en;
  logic [7:0]                 line_depth;
  logic [WIDTH-1:0]           row1_pix;
  logic [WIDTH-1:0]           row2_pix;
  logic                       out_valid;
  logic                       out_ready;
  logic [WIN_WORDS*WIDTH-1:0] out_win;

  modport master (
    output cfg_cols, cfg_rows, cfg_stride2, start, in_valid, in_pix, row1_pix, row2_pix,
           out_ready,
    input  busy, done, in_ready, line_en, line_depth, out_valid, out_win
  );

  modport slave (
    input  cfg_cols, cfg_rows, cfg_stride2, start, in_valid, in_pix, row1_pix, row2_pix,
           out_ready,
    output busy, done, in_ready, line_en, line_depth, out_valid, out_win
  );

endinterface

// File: rtl/conv_window_gen_pos_counter.sv
// Raster column/row position tracking with last-pixel and window-emit flags.
module win_pos_counter (
  input  logic       clk,
  input  logic       rst,
  input  logic       clear,
  input  logic       advance,
  input  logic [7:0] cols,
  input  logic [7:0] rows,
  input  logic       stride2,
  output logic       emit,
  output logic       last
);

  logic [7:0] col_q;
  logic [7:0] row_q;
  logic       col_wrap;

  assign col_wrap = (col_q == cols - 8'd1);
  assign last     = col_wrap && (row_q == rows - 8'd1);
  // Valid padding: a window is complete once two full rows and columns precede it.
  assign emit     = (row_q >= 8'd2) && (col_q >= 8'd2) &&
                    (!stride2 || (!row_q[0] && !col_q[0]));

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      col_q <= 8'd0;
      row_q <= 8'd0;
    end else if (advance) begin
      if (col_wrap) begin
        col_q <= 8'd0;
        row_q <= row_q + 8'd1;
      end else begin
        col_q <= col_q + 8'd1;
      end
    end
  end

endmodule

// File: rtl/conv_window_gen.sv
// Streaming 3x3 window generator fed by two row-delay line buffers.
module conv_window_gen
  import conv_pkg::*;
#(
  parameter int unsigned WIDTH    = 64,
  parameter int unsigned MAX_COLS = 128
) (
  input logic              clk,
  input logic              rst,
  conv_window_gen_if.slave bus
);

  win_state_t                 state;
  logic [7:0]                 cols_q;
  logic [7:0]                 rows_q;
  logic                       stride2_q;
  logic [WIDTH-1:0]           win_q [WIN_WORDS];
  logic [WIDTH-1:0]           win_d [WIN_WORDS];
  logic [WIN_WORDS*WIDTH-1:0] win_flat_d;
  logic                       advance;
  logic                       emit;
  logic                       last;
  logic                       cfg_ok;

  assign cfg_ok = (cols_q >= 8'd3) && (rows_q >= 8'd3) && ({24'd0, cols_q} <= MAX_COLS);

  assign bus.in_ready = (state == StRun) && cfg_ok && (!bus.out_valid || bus.out_ready);
  assign advance      = bus.in_valid && bus.in_ready;
  assign bus.line_en  = advance;

  win_pos_counter u_pos (
    .clk     (clk),
    .rst     (rst),
    .clear   (state == StIdle),
    .advance (advance),
    .cols    (cols_q),
    .rows    (rows_q),
    .stride2 (stride2_q),
    .emit    (emit),
    .last    (last)
  );

  // Row 0 (top) is the oldest row, so it comes from the deepest line buffer.
  always_comb begin
    for (int i = 0; i < WIN_K; i++) begin
      win_d[WIN_K*i]     = win_q[WIN_K*i + 1];
      win_d[WIN_K*i + 1] = win_q[WIN_K*i + 2];
      win_d[WIN_K*i + 2] = win_q[WIN_K*i + 2];
    end
    win_d[2] = bus.row2_pix;
    win_d[5] = bus.row1_pix;
    win_d[8] = bus.in_pix;
  end

  always_comb begin
    win_flat_d = '0;
    for (int k = 0; k < WIN_WORDS; k++) begin
      win_flat_d[k*WIDTH +: WIDTH] = win_d[k];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= StIdle;
      cols_q         <= 8'd0;
      rows_q         <= 8'd0;
      stride2_q      <= 1'b0;
      bus.busy       <= 1'b0;
      bus.done       <= 1'b0;
      bus.out_valid  <= 1'b0;
      bus.out_win    <= '0;
      bus.line_depth <= 8'd0;
      for (int k = 0; k < WIN_WORDS; k++) begin
        win_q[k] <= '0;
      end
    end else begin
      bus.done <= 1'b0;
      if (advance) begin
        win_q <= win_d;
      end
      if (advance && emit) begin
        bus.out_valid <= 1'b1;
        bus.out_win   <= win_flat_d;
      end else if (bus.out_ready) begin
        bus.out_valid <= 1'b0;
      end

      unique case (state)
        StIdle: begin
          if (bus.start) begin
            cols_q         <= bus.cfg_cols;
            rows_q         <= bus.cfg_rows;
            stride2_q      <= bus.cfg_stride2;
            bus.line_depth <= bus.cfg_cols;
            bus.busy       <= 1'b1;
            state          <= StRun;
          end
        end
        StRun: begin
          if (!cfg_ok) begin
            bus.done <= 1'b1;
            bus.busy <= 1'b0;
            state    <= StDone;
          end else if (advance && last) begin
            state <= StDrain;
          end
        end
        StDrain: begin
          if (!bus.out_valid || bus.out_ready) begin
            bus.done <= 1'b1;
            bus.busy <= 1'b0;
            state    <= StDone;
          end
        end
        StDone:  state <= StIdle;
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_conv_window_gen.sv
// Directed bench for conv_window_gen with a behavioural line-buffer and window model.
module tb_conv_window_gen;
  import conv_pkg::*;

  localparam int unsigned W  = 64;
  localparam int unsigned WW = WIN_WORDS * W;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  conv_window_gen_if #(.WIDTH(W)) bus ();

  conv_window_gen #(
    .WIDTH    (W),
    .MAX_COLS (128)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int            n_checks = 0;
  int            n_errors = 0;
  int            fid      = 0;
  logic [WW-1:0] exp_q [$];

  task automatic check(input string tag, input logic [WW-1:0] got, input logic [WW-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [W-1:0] pix(input int r, input int c);
    if (r < 0) return '1;
    return W'(fid * 4096 + r * 16 + c);
  endfunction

  task automatic build_exp(input int cols, input int rows, input bit s2);
    exp_q.delete();
    for (int r = 2; r < rows; r++) begin
      for (int c = 2; c < cols; c++) begin
        if (!s2 || (r % 2 == 0 && c % 2 == 0)) begin
          logic [WW-1:0] w;
          w = '0;
          for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++)
              w[(3*i+j)*W +: W] = pix(r - 2 + i, c - 2 + j);
          exp_q.push_back(w);
        end
      end
    end
  endtask

  task automatic check_reset_outs(input string tag);
    check({tag, "_ctl"}, WW'({bus.busy, bus.done, bus.in_ready, bus.line_en, bus.out_valid,
                              bus.line_depth}), '0);
    check({tag, "_win"}, bus.out_win, '0);
  endtask

  // Starts at #1 after a posedge with the DUT idle; returns the same way.
  task automatic run_frame(input int cols, input int rows, input bit s2, input bit rnd,
                           input bit disturb);
    int            pr, pc, got, done_k, last_adv, nexp;
    bit            adv, stalled_prev, pix_done;
    logic [WW-1:0] prev_win;
    fid++;
    build_exp(cols, rows, s2);
    nexp = exp_q.size();
    bus.cfg_cols    = 8'(cols);
    bus.cfg_rows    = 8'(rows);
    bus.cfg_stride2 = s2;
    bus.start       = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    if (disturb) begin
      bus.cfg_cols    = 8'd6;
      bus.cfg_rows    = 8'd6;
      bus.cfg_stride2 = ~s2;
    end
    pr = 0; pc = 0; got = 0; done_k = -1; last_adv = -1;
    stalled_prev = 1'b0; pix_done = 1'b0; prev_win = '0;
    for (int k = 0; k < 3000 && done_k < 0; k++) begin
      bus.in_pix    = pix(pr, pc);
      bus.row1_pix  = pix(pr - 1, pc);
      bus.row2_pix  = pix(pr - 2, pc);
      bus.in_valid  = !pix_done;
      bus.out_ready = rnd ? ($urandom_range(0, 2) != 0) : 1'b1;
      bus.start     = disturb && (k == 7);
      @(negedge clk);
      if (stalled_prev) check("hold", bus.out_win, prev_win);
      if (bus.out_valid && !bus.out_ready) check("stall", WW'({bus.in_ready, bus.line_en}), '0);
      if (bus.out_valid && bus.out_ready) begin
        if (got < nexp) check($sformatf("win%0d_f%0d", got, fid), bus.out_win, exp_q[got]);
        got++;
      end
      if (bus.done) begin
        done_k = k;
        check("busy_at_done", WW'(bus.busy), '0);
      end
      adv = bus.in_valid && bus.in_ready;
      if (adv) last_adv = k;
      stalled_prev = bus.out_valid && !bus.out_ready;
      prev_win     = bus.out_win;
      @(posedge clk); #1;
      if (adv) begin
        if (pc == cols - 1) begin
          pc = 0;
          pr++;
        end else begin
          pc++;
        end
        if (pr == rows) pix_done = 1'b1;
      end
    end
    bus.in_valid = 1'b0;
    bus.start    = 1'b0;
    check($sformatf("win_count_f%0d", fid), WW'(got), WW'(nexp));
    check("done_seen", WW'(done_k >= 0), WW'(1));
    if (!rnd) check("done_lat", WW'(done_k - last_adv), WW'(2));
  endtask

  initial begin
    int done_k;
    bus.cfg_cols = 8'd0; bus.cfg_rows = 8'd0; bus.cfg_stride2 = 1'b0; bus.start = 1'b0;
    bus.in_valid = 1'b0; bus.in_pix = '0; bus.row1_pix = '0; bus.row2_pix = '0;
    bus.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset_outs("reset");
    @(posedge clk); #1;
    rst = 1'b0;

    // Hand-checked anchor: first stride-1 window of a 5x4 ramp frame.
    fid = 0;
    build_exp(5, 4, 1'b0);
    check("anchor_first_win", exp_q[0],
          {64'd34, 64'd33, 64'd32, 64'd18, 64'd17, 64'd16, 64'd2, 64'd1, 64'd0});
    fid = -1;

    run_frame(5, 4, 1'b0, 1'b0, 1'b0);
    run_frame(6, 6, 1'b1, 1'b0, 1'b0);
    run_frame(7, 5, 1'b0, 1'b1, 1'b0);
    run_frame(6, 5, 1'b1, 1'b1, 1'b0);
    run_frame(5, 4, 1'b0, 1'b1, 1'b1);

    // Illegal width: straight to done without accepting pixels.
    bus.cfg_cols = 8'd2; bus.cfg_rows = 8'd4; bus.cfg_stride2 = 1'b0;
    bus.in_valid = 1'b1; bus.out_ready = 1'b1; bus.start = 1'b1;
    done_k = -1;
    for (int n = 0; n < 6; n++) begin
      @(negedge clk);
      check("bad_in_ready", WW'(bus.in_ready), '0);
      if (bus.done && done_k < 0) done_k = n;
      @(posedge clk); #1;
      bus.start = 1'b0;
    end
    check("bad_done_lat", WW'(done_k), WW'(2));

    // Mid-frame reset while a window is stalled at the output.
    bus.cfg_cols = 8'd5; bus.cfg_rows = 8'd4; bus.start = 1'b1;
    bus.out_ready = 1'b0;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (14) @(posedge clk);
    @(negedge clk);
    check("pre_rst_valid", WW'(bus.out_valid), WW'(1));
    @(posedge clk); #1;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_reset_outs("midrst");
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    run_frame(5, 4, 1'b0, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/conv_window_gen.md
# conv_window_gen

Streaming 3×3 window generator for the convolution engine. It sits directly downstream of the two line-buffer delay lines and consumes their outputs. It accepts one pixel word per advance and drives the shared enable and depth of the line buffers. From the current pixel and the two row-delayed pixels it assembles a 3×3 window and emits valid-padding windows at stride 1 or 2 over a valid/ready handshake.

## Interface
Parameters:
- WIDTH, 64, bits per pixel word (channel-packed); must match the line buffers.
- MAX_COLS, 128, largest supported row length; matches line-buffer depth.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- cfg_cols  in  8  frame width in pixels, legal 3..MAX_COLS
- cfg_rows  in  8  frame height, legal 3..255
- cfg_stride2  in  1  0 = stride 1, 1 = stride 2
- start  in  1  one-cycle pulse; latches cfg_* and begins a frame
- busy  out  1  high from accepted start until done
- done  out  1  one-cycle pulse at frame end
- in_valid  in  1  upstream pixel valid
- in_ready  out  1  block accepts pixel
- in_pix  in  WIDTH  current pixel (r, c), raster order
- line_en  out  1  enable to both line buffers; equals advance
- line_depth  out  8  delay depth to line buffers; equals latched cfg_cols
- row1_pix  in  WIDTH  line-buffer output, pixel (r-1, c), aligned with in_pix
- row2_pix  in  WIDTH  second line-buffer output, pixel (r-2, c), aligned with in_pix
- out_valid  out  1  window valid
- out_ready  in  1  downstream accepts window
- out_win  out  9·WIDTH  window; word index 3·i+j = row i (0 = top), col j (0 = left)

## Operation
- FSM states: IDLE, RUN, DRAIN, DONE.
- IDLE: start loads cfg_cols, cfg_rows and cfg_stride2 into registers, clears counters, and sets busy.
  - Next state is RUN.
  - If the latched cols < 3 or rows < 3, next state is DONE and no windows are produced.
- RUN: advance = in_valid && in_ready.
  - in_ready = (state == RUN) && (!out_valid || out_ready).
  - On advance, the column {row2_pix, row1_pix, in_pix} shifts into the 3×3 register. The new column enters at j = 2 and the old columns move left.
  - The col counter increments on each advance and wraps at cols-1 to 0; the row counter increments on wrap.
- A window is emitted on an advance when r ≥ 2 and c ≥ 2.
  - For stride 2, r and c must also both be even.
  - The shifted window (including the new column) is loaded into out_win, and out_valid is set.
- out_valid clears on out_ready when no new window loads in that same cycle. A simultaneous load with out_ready high keeps out_valid = 1 and takes the new data.
- An advance at (rows-1, cols-1) moves the FSM to DRAIN. DRAIN waits until !out_valid || out_ready, then moves to DONE.
- DONE: done = 1 for one cycle and busy clears; next state is IDLE.
- start is ignored while busy. cfg_* changes after start have no effect.
- Window count per frame:
  - stride 1: (rows-2)·(cols-2)
  - stride 2: floor((rows-1)/2)·floor((cols-1)/2)

## Timing
- Reset values: busy = 0, done = 0, in_ready = 0, line_en = 0, out_valid = 0, out_win = 0, line_depth = 0, state IDLE, counters 0.
- line_en is combinational from advance. All other outputs are registered.
- Latency: the advance that completes a window produces out_valid = 1 on the next cycle.
- Throughput: one pixel per cycle while out_ready is held high.
- Backpressure: when out_valid && !out_ready, in_ready = 0 and line_en = 0, so the line buffers freeze in lock-step.
- rst mid-frame aborts immediately to the reset values; no done pulse is issued. The line buffers share the same rst.

## Structure
- Shared package conv_pkg holds:
  - the state enum type win_state_t
  - the constant WIN_K = 3
  - the localparam for window word count (9)
- Optional single sub-module win_pos_counter: the col/row counters with wrap, last-pixel flag and emit-condition logic.

## Test plan
- Reset: assert rst for 2 cycles mid-frame → all outputs 0, state IDLE; a new start then runs cleanly.
- cols = 5, rows = 4, stride 1, out_ready = 1, in_pix = ramp r·16+c, row taps from a model → exactly 6 windows. The first has the centre at (1,1), with top row {0,1,2}, middle row {16,17,18} and bottom row {32,33,34}; done follows one cycle after the last window is accepted.
- cols = 6, rows = 6, stride 2 → exactly 4 windows, with the bottom-right word at (2,2), (2,4), (4,2), (4,4).
- Random out_ready deassertion → in_ready and line_en low while stalled, no window lost or duplicated, and out_win stable while out_valid && !out_ready.
- cfg_cols = 2 start → no windows, in_ready never high, done pulse 2 cycles after start.
- start pulsed while busy, and cfg_* changed mid-frame → ignored; output matches the frame as originally configured.
